// File: rtl/sha_256_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha_256_padder
//  Description : Byte-stream to 512-bit block padder for SHA-256. Appends
//                0x80, zero fill and the 64-bit big-endian message bit length.
//  Revision    : 1.0  initial release
// ============================================================================
module sha_256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] out_block,
  output logic         out_first,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_PAD    = 2'd1,
    S_LENBLK = 2'd2,
    S_EMIT   = 2'd3
  } state_t;

  localparam logic [5:0] c_LEN_POS = 6'd56;

  state_t           r_state;
  logic [7:0]       r_buf [64];
  logic [5:0]       r_ptr;
  logic [LEN_W-1:0] r_bitlen;
  logic             r_first_pend;
  logic             r_pad_pend;
  logic             r_need_len;
  logic             r_out_last;
  logic [63:0]      w_len64;

  assign w_len64 = 64'(r_bitlen);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FILL;
      r_ptr        <= 6'd0;
      r_bitlen     <= '0;
      r_first_pend <= 1'b1;
      r_pad_pend   <= 1'b0;
      r_need_len   <= 1'b0;
      r_out_last   <= 1'b0;
      for (int i = 0; i < 64; i++) r_buf[i] <= 8'h00;
    end else begin
      case (r_state)
        S_FILL: begin
          if (in_valid) begin
            r_buf[r_ptr] <= in_data;
            r_ptr        <= r_ptr + 6'd1;
            r_bitlen     <= r_bitlen + LEN_W'(8);
            if (r_ptr == 6'd63) begin
              r_state    <= S_EMIT;
              r_out_last <= 1'b0;
              r_pad_pend <= in_last;
            end else if (in_last) begin
              r_state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          // Length fits behind the 0x80 only if at least 8 bytes remain.
          for (int i = 0; i < 64; i++) begin
            if (6'(i) == r_ptr)
              r_buf[i] <= 8'h80;
            else if (6'(i) > r_ptr) begin
              if (i >= 56 && r_ptr < c_LEN_POS)
                r_buf[i] <= 8'(w_len64 >> (8 * (63 - i)));
              else
                r_buf[i] <= 8'h00;
            end
          end
          r_out_last <= (r_ptr < c_LEN_POS);
          r_need_len <= (r_ptr >= c_LEN_POS);
          r_state    <= S_EMIT;
        end
        S_LENBLK: begin
          for (int i = 0; i < 64; i++) begin
            if (i >= 56)
              r_buf[i] <= 8'(w_len64 >> (8 * (63 - i)));
            else
              r_buf[i] <= 8'h00;
          end
          r_out_last <= 1'b1;
          r_state    <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            r_ptr        <= 6'd0;
            r_first_pend <= r_out_last;
            if (r_out_last) begin
              r_bitlen <= '0;
              r_state  <= S_FILL;
            end else if (r_pad_pend) begin
              // Message ended on a block boundary: padding gets its own block.
              r_pad_pend <= 1'b0;
              r_state    <= S_PAD;
            end else if (r_need_len) begin
              r_need_len <= 1'b0;
              r_state    <= S_LENBLK;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  for (genvar g = 0; g < 64; g++) begin : g_pack
    assign out_block[511-8*g -: 8] = r_buf[g];
  end

  assign in_ready  = (r_state == S_FILL);
  assign out_valid = (r_state == S_EMIT);
  assign out_first = out_valid & r_first_pend;
  assign out_last  = out_valid & r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_sha_256_padder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha_256_padder
//  Description : Directed self-checking bench for sha_256_padder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha_256_padder;

  logic         clk;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] out_block;
  logic         out_first;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   msg [256];
  logic [511:0] last_blk;

  localparam logic [511:0] c_ABC_BLK = {32'h61626380, 416'h0, 64'h18};

  sha_256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_block (out_block),
    .out_first (out_first),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference padding of msg[0..len-1], block k, byte 0 at [511:504].
  function automatic logic [511:0] exp_block(input int len, input int k);
    logic [511:0] b;
    logic [63:0]  l64;
    logic [7:0]   v;
    int p, j;
    p   = ((len + 8) / 64 + 1) * 64;
    l64 = 64'(len) * 64'd8;
    b   = '0;
    for (int i = 0; i < 64; i++) begin
      j = 64 * k + i;
      if (j < len)          v = msg[j];
      else if (j == len)    v = 8'h80;
      else if (j >= p - 8)  v = 8'(l64 >> (8 * (p - 1 - j)));
      else                  v = 8'h00;
      b[511-8*i -: 8] = v;
    end
    return b;
  endfunction

  task automatic send_bytes(input int n, input bit with_last);
    int t;
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b1;
      in_data  = msg[j];
      in_last  = with_last && (j == n - 1);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) check("send_timeout", 512'(in_ready), 512'(1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_block(output logic [511:0] blk, output logic first, output logic last);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) check("block_timeout", 512'(out_valid), 512'(1));
    blk   = out_block;
    first = out_first;
    last  = out_last;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic collect_msg(input int len, input string tag);
    logic [511:0] blk;
    logic f, l;
    int nblk;
    nblk = (len + 8) / 64 + 1;
    for (int k = 0; k < nblk; k++) begin
      get_block(blk, f, l);
      check($sformatf("%s_blk%0d", tag, k), blk, exp_block(len, k));
      check($sformatf("%s_first%0d", tag, k), 512'(f), 512'(k == 0));
      check($sformatf("%s_last%0d", tag, k), 512'(l), 512'(k == nblk - 1));
      last_blk = blk;
    end
  endtask

  task automatic load_abc();
    msg[0] = 8'h61;
    msg[1] = 8'h62;
    msg[2] = 8'h63;
  endtask

  task automatic load_pattern(input bit zeros);
    for (int j = 0; j < 256; j++) msg[j] = zeros ? 8'h00 : 8'(j * 7 + 3);
  endtask

  initial begin
    logic [511:0] hold_blk;
    logic         hold_first, hold_last;
    int           t;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    last_blk = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready",  512'(in_ready),  512'(1));
    check("rst_out_valid", 512'(out_valid), 512'(0));
    check("rst_out_first", 512'(out_first), 512'(0));
    check("rst_out_last",  512'(out_last),  512'(0));
    check("rst_out_block", out_block,       512'(0));

    // "abc" with latency check: PAD cycle, then EMIT.
    load_abc();
    send_bytes(3, 1'b1);
    check("abc_lat_pad", 512'(out_valid), 512'(0));
    @(posedge clk);
    #1;
    check("abc_lat_emit", 512'(out_valid), 512'(1));
    collect_msg(3, "abc");
    check("abc_const", last_blk, c_ABC_BLK);

    // 55 zero bytes: 0x80 at byte 55, length in the same block.
    load_pattern(1'b1);
    send_bytes(55, 1'b1);
    collect_msg(55, "z55");
    check("z55_byte55", 512'(last_blk[71:64]), 512'(8'h80));
    check("z55_len",    512'(last_blk[63:0]),  512'(64'h1B8));

    // 56 bytes, with backpressure on the first block.
    load_pattern(1'b0);
    send_bytes(56, 1'b1);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid", 512'(out_valid), 512'(1));
    hold_blk = out_block; hold_first = out_first; hold_last = out_last;
    check("bp_first0", 512'(hold_first), 512'(1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_blk_c%0d", c),   out_block,           hold_blk);
      check($sformatf("bp_flags_c%0d", c), 512'({out_first, out_last, out_valid}),
                                           512'({hold_first, hold_last, 1'b1}));
      check($sformatf("bp_rdy_c%0d", c),   512'(in_ready),      512'(0));
    end
    @(posedge clk);
    #1;
    collect_msg(56, "m56");
    check("m56_len", 512'(last_blk[63:0]), 512'(64'h1C0));

    // 64 bytes: full data block is out the cycle after the last byte.
    send_bytes(64, 1'b1);
    check("m64_lat",   512'(out_valid), 512'(1));
    check("m64_ready", 512'(in_ready),  512'(0));
    collect_msg(64, "m64");
    check("m64_len",   512'(last_blk[63:0]), 512'(64'h200));
    check("m64_80",    512'(last_blk[511:504]), 512'(8'h80));

    // 128 bytes: sender stalls while blocks are drained.
    fork
      send_bytes(128, 1'b1);
      collect_msg(128, "m128");
    join
    check("m128_len", 512'(last_blk[63:0]), 512'(64'h400));

    // Two back-to-back messages, each starting with out_first.
    load_abc();
    send_bytes(3, 1'b1);
    collect_msg(3, "b2b0");
    send_bytes(3, 1'b1);
    collect_msg(3, "b2b1");

    // Reset mid-message drops it.
    load_pattern(1'b0);
    send_bytes(20, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mrst_in_ready",  512'(in_ready),  512'(1));
    check("mrst_out_valid", 512'(out_valid), 512'(0));
    load_abc();
    send_bytes(3, 1'b1);
    collect_msg(3, "mrst_abc");
    check("mrst_abc_const", last_blk, c_ABC_BLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running required finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
